// File: rtl/eprisc_bus_arbiter_if.sv
// eprisc_bus_arbiter_if
//   Groups the requester handshake and the system-bus strobe/ready signals
//   that pass through the epRISC bus arbiter.
//   Requester side : iReq, iWrite, iAddr0..2, iWData0..2 in; oGnt, oAck, oErr, oRData out
//   Bus side       : oBusAddr, oBusWData, oBusWrite, oBusStrobe out; iBusRData, iBusReady in
//   Status         : oBusy out
//   Modport slave  : the arbiter's view. It serves the masters and drives the bus.
//   Modport master : the environment's view. That is the requesters plus the bus slave.
interface eprisc_bus_arbiter_if;
   logic [2:0]  iReq;
   logic [2:0]  iWrite;
   logic [31:0] iAddr0;
   logic [31:0] iAddr1;
   logic [31:0] iAddr2;
   logic [31:0] iWData0;
   logic [31:0] iWData1;
   logic [31:0] iWData2;
   logic [2:0]  oGnt;
   logic [2:0]  oAck;
   logic        oErr;
   logic [31:0] oRData;
   logic [31:0] oBusAddr;
   logic [31:0] oBusWData;
   logic        oBusWrite;
   logic        oBusStrobe;
   logic [31:0] iBusRData;
   logic        iBusReady;
   logic        oBusy;

   modport slave (
      input  iReq, iWrite, iAddr0, iAddr1, iAddr2, iWData0, iWData1, iWData2,
      input  iBusRData, iBusReady,
      output oGnt, oAck, oErr, oRData, oBusAddr, oBusWData, oBusWrite, oBusStrobe, oBusy
   );

   modport master (
      output iReq, iWrite, iAddr0, iAddr1, iAddr2, iWData0, iWData1, iWData2,
      output iBusRData, iBusReady,
      input  oGnt, oAck, oErr, oRData, oBusAddr, oBusWData, oBusWrite, oBusStrobe, oBusy
   );
endinterface

// File: rtl/eprisc_bus_arbiter.sv
// eprisc_bus_arbiter
//   Shares the epRISC system bus between three masters. The masters are
//   debug (0), core (1) and DMA (2). Each grant carries one single-word
//   read or write. Debug has fixed priority, and core and DMA alternate on a
//   tie. A ready timeout aborts the transaction when a slave hangs.
//   Ports:
//     iClk : system clock, rising edge
//     iRst : synchronous active-high reset
//     bus  : eprisc_bus_arbiter_if.slave, carrying the requester and bus signals
//   All outputs come straight from registers. oBusy is a decode of the state register.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | bus free; arbitrate on iReq
//   WAIT  | strobe asserted, waiting for iBusReady or timeout
//   DONE  | one-cycle oAck (and oErr on timeout) to the winner
module eprisc_bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic                 iClk,
   input  logic                 iRst,
   eprisc_bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   // Last wait-counter value before the timeout fires. It is unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t           state_q,  state_d;
   logic [2:0]       gnt_q,    gnt_d;
   logic [2:0]       ack_q,    ack_d;
   logic             err_q,    err_d;
   logic [31:0]      rdata_q,  rdata_d;
   logic [31:0]      addr_q,   addr_d;
   logic [31:0]      wdata_q,  wdata_d;
   logic             write_q,  write_d;
   logic             strobe_q, strobe_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [1:0]       last_q,   last_d;
   logic [1:0]       win_q,    win_d;
   logic [1:0]       sel;
   logic             timed_out;

   // Winner selection. Debug always wins. On a core/DMA tie, the one that did not go last wins.
   always_comb begin
      sel = 2'd2;
      if (bus.iReq[0])                     sel = 2'd0;
      else if (bus.iReq[1] && bus.iReq[2]) sel = (last_q == 2'd1) ? 2'd2 : 2'd1;
      else if (bus.iReq[1])                sel = 2'd1;
   end

   assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ack_d    = 3'b000;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      strobe_d = strobe_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      win_d    = win_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.iReq) begin
               win_d    = sel;
               gnt_d    = 3'b001 << sel;
               strobe_d = 1'b1;
               cnt_d    = '0;
               write_d  = bus.iWrite[sel];
               case (sel)
                  2'd0:    begin addr_d = bus.iAddr0; wdata_d = bus.iWData0; end
                  2'd1:    begin addr_d = bus.iAddr1; wdata_d = bus.iWData1; end
                  default: begin addr_d = bus.iAddr2; wdata_d = bus.iWData2; end
               endcase
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.iBusReady || timed_out) begin
               // Ready has priority over a coincident timeout.
               rdata_d  = bus.iBusReady ? bus.iBusRData : 32'h0;
               err_d    = ~bus.iBusReady;
               ack_d    = 3'b001 << win_q;
               gnt_d    = 3'b000;
               strobe_d = 1'b0;
               if (win_q != 2'd0) last_d = win_q;
               state_d  = ST_DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= 3'b000;
         ack_q    <= 3'b000;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         write_q  <= 1'b0;
         strobe_q <= 1'b0;
         cnt_q    <= '0;
         last_q   <= 2'd2;
         win_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         strobe_q <= strobe_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         win_q    <= win_d;
      end
   end

   assign bus.oGnt       = gnt_q;
   assign bus.oAck       = ack_q;
   assign bus.oErr       = err_q;
   assign bus.oRData     = rdata_q;
   assign bus.oBusAddr   = addr_q;
   assign bus.oBusWData  = wdata_q;
   assign bus.oBusWrite  = write_q;
   assign bus.oBusStrobe = strobe_q;
   assign bus.oBusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// tb_eprisc_bus_arbiter
//   Tests eprisc_bus_arbiter against a transaction-level model of the
//   arbitration rule and the handshake timing. The bench checks directed
//   scenarios first and then runs randomized traffic.
module tb_eprisc_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eprisc_bus_arbiter_if ifc ();

   eprisc_bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (ifc.slave)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Model state: the requester inputs, plus which of core/DMA was served last.
   logic [2:0]  req_m;
   logic [2:0]  wr_m;
   logic [31:0] a_m [3];
   logic [31:0] d_m [3];
   int          last_m;
   logic [31:0] rd_hold;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_masters();
      ifc.iReq    = req_m;
      ifc.iWrite  = wr_m;
      ifc.iAddr0  = a_m[0];
      ifc.iAddr1  = a_m[1];
      ifc.iAddr2  = a_m[2];
      ifc.iWData0 = d_m[0];
      ifc.iWData1 = d_m[1];
      ifc.iWData2 = d_m[2];
   endtask

   function automatic int pick(input logic [2:0] r);
      if (r[0])         return 0;
      if (r[1] && r[2]) return (last_m == 1) ? 2 : 1;
      if (r[1])         return 1;
      return 2;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_gnt",    32'(ifc.oGnt),       32'h0);
      chk("rst_ack",    32'(ifc.oAck),       32'h0);
      chk("rst_err",    32'(ifc.oErr),       32'h0);
      chk("rst_rdata",  ifc.oRData,          32'h0);
      chk("rst_addr",   ifc.oBusAddr,        32'h0);
      chk("rst_wdata",  ifc.oBusWData,       32'h0);
      chk("rst_write",  32'(ifc.oBusWrite),  32'h0);
      chk("rst_strobe", 32'(ifc.oBusStrobe), 32'h0);
      chk("rst_busy",   32'(ifc.oBusy),      32'h0);
      rst     = 1'b0;
      last_m  = 2;
      rd_hold = 32'h0;
   endtask

   // One transaction, starting with the arbiter in IDLE and req_m non-zero.
   // n is the number of WAIT edges without ready before the slave answers.
   // Any n >= 16 means the slave never answers within the timeout.
   task automatic run_txn(input int n, input logic [31:0] rdv, input logic [2:0] mid_add,
                          input bit drop_mid, input bit scramble);
      int          w;
      int          d;
      bit          err;
      logic [2:0]  g;
      logic [31:0] ea;
      logic [31:0] ed;
      logic        ew;
      w  = pick(req_m);
      g  = 3'b001 << w;
      ea = a_m[w];
      ed = d_m[w];
      ew = wr_m[w];
      drive_masters();
      ifc.iBusReady = 1'($urandom_range(0, 1));
      ifc.iBusRData = $urandom;
      tick();
      chk("gnt",    32'(ifc.oGnt),       32'(g));
      chk("strobe", 32'(ifc.oBusStrobe), 32'h1);
      chk("addr",   ifc.oBusAddr,        ea);
      chk("wdata",  ifc.oBusWData,       ed);
      chk("write",  32'(ifc.oBusWrite),  32'(ew));
      chk("busy",   32'(ifc.oBusy),      32'h1);
      chk("ack0",   32'(ifc.oAck),       32'h0);
      if (scramble) begin
         a_m[w] = $urandom;
         d_m[w] = $urandom;
         wr_m[w] = ~wr_m[w];
         drive_masters();
      end
      err = (n >= 16);
      d   = err ? 15 : n;
      ifc.iBusReady = 1'b0;
      for (int k = 0; k < d; k++) begin
         if (k == d / 2) begin
            req_m = req_m | mid_add;
            if (drop_mid) req_m[w] = 1'b0;
            drive_masters();
         end
         tick();
         chk("wait_strobe", 32'(ifc.oBusStrobe), 32'h1);
         chk("wait_gnt",    32'(ifc.oGnt),       32'(g));
         chk("wait_addr",   ifc.oBusAddr,        ea);
         chk("wait_wdata",  ifc.oBusWData,       ed);
         chk("wait_ack",    32'(ifc.oAck),       32'h0);
      end
      ifc.iBusRData = rdv;
      ifc.iBusReady = ~err;
      tick();
      rd_hold = err ? 32'h0 : rdv;
      chk("ack",        32'(ifc.oAck),       32'(g));
      chk("err",        32'(ifc.oErr),       32'(err));
      chk("rdata",      ifc.oRData,          rd_hold);
      chk("done_gnt",   32'(ifc.oGnt),       32'h0);
      chk("done_strobe",32'(ifc.oBusStrobe), 32'h0);
      chk("done_busy",  32'(ifc.oBusy),      32'h1);
      if (w != 0) last_m = w;
      req_m[w] = 1'b0;
      drive_masters();
      ifc.iBusReady = 1'($urandom_range(0, 1));
      ifc.iBusRData = $urandom;
      tick();
      chk("idle_ack",   32'(ifc.oAck),       32'h0);
      chk("idle_err",   32'(ifc.oErr),       32'h0);
      chk("idle_busy",  32'(ifc.oBusy),      32'h0);
      chk("idle_strobe",32'(ifc.oBusStrobe), 32'h0);
      chk("rdata_hold", ifc.oRData,          rd_hold);
   endtask

   initial begin
      req_m = 3'b000;
      wr_m  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a_m[i] = 32'h0;
         d_m[i] = 32'h0;
      end
      last_m  = 2;
      rd_hold = 32'h0;
      drive_masters();
      ifc.iBusReady = 1'b0;
      ifc.iBusRData = 32'h0;

      do_reset();

      // Core read, zero-wait slave.
      req_m   = 3'b010;
      wr_m    = 3'b000;
      a_m[1]  = 32'h100;
      run_txn(0, 32'hCAFEF00D, 3'b000, 1'b0, 1'b0);

      // Steady core+DMA contention alternates, starting with DMA because core just went.
      for (int i = 0; i < 4; i++) begin
         req_m  = 3'b110;
         a_m[1] = 32'h1000 + 32'(i);
         a_m[2] = 32'h2000 + 32'(i);
         run_txn(0, $urandom, 3'b000, 1'b0, 1'b0);
      end

      // All three masters at once after a reset: debug, then core, then DMA.
      do_reset();
      req_m = 3'b111;
      wr_m  = 3'b101;
      for (int i = 0; i < 3; i++) begin
         a_m[i] = 32'h30 + 32'(i);
         d_m[i] = 32'hD0D0_0000 + 32'(i);
      end
      for (int i = 0; i < 3; i++) run_txn(1, $urandom, 3'b000, 1'b0, 1'b0);

      // Hung slave: timeout, then a normal transaction.
      req_m = 3'b100;
      run_txn(40, 32'hFFFF_FFFF, 3'b000, 1'b0, 1'b0);
      req_m = 3'b010;
      run_txn(2, 32'h1234_5678, 3'b000, 1'b0, 1'b0);

      // Ready and timeout on the same edge.
      req_m = 3'b001;
      run_txn(15, 32'h5555_AAAA, 3'b000, 1'b0, 1'b0);

      // Debug raises its request during a core wait, with no preemption.
      req_m = 3'b010;
      run_txn(5, $urandom, 3'b001, 1'b0, 1'b0);
      run_txn(0, $urandom, 3'b000, 1'b0, 1'b0);

      // Reset during the third WAIT cycle of a DMA write.
      req_m  = 3'b100;
      wr_m   = 3'b100;
      a_m[2] = 32'hDEAD_0000;
      d_m[2] = 32'h0BAD_F00D;
      drive_masters();
      ifc.iBusReady = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_gnt",    32'(ifc.oGnt),       32'h0);
      chk("mid_rst_ack",    32'(ifc.oAck),       32'h0);
      chk("mid_rst_strobe", 32'(ifc.oBusStrobe), 32'h0);
      chk("mid_rst_addr",   ifc.oBusAddr,        32'h0);
      chk("mid_rst_wdata",  ifc.oBusWData,       32'h0);
      chk("mid_rst_write",  32'(ifc.oBusWrite),  32'h0);
      chk("mid_rst_rdata",  ifc.oRData,          32'h0);
      chk("mid_rst_busy",   32'(ifc.oBusy),      32'h0);
      rst     = 1'b0;
      last_m  = 2;
      rd_hold = 32'h0;
      req_m   = 3'b000;
      drive_masters();
      tick();
      chk("post_rst_ack", 32'(ifc.oAck), 32'h0);
      req_m = 3'b110;
      run_txn(0, $urandom, 3'b000, 1'b0, 1'b0);

      // Randomized traffic.
      for (int it = 0; it < 200; it++) begin
         int n;
         for (int i = 0; i < 3; i++) begin
            if (!req_m[i]) begin
               a_m[i]  = $urandom;
               d_m[i]  = $urandom;
               wr_m[i] = 1'($urandom_range(0, 1));
            end
         end
         req_m = req_m | 3'($urandom_range(0, 7));
         if (req_m == 3'b000) req_m = 3'b001 << $urandom_range(0, 2);
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
         run_txn(n, $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eprisc_bus_arbiter.md
Name: eprisc_bus_arbiter

Overview:
- Shares the single epRISC system bus between three masters: debug port (requester 0), epRISC core (requester 1), DMA engine (requester 2).
- Runs one single-word read or write per grant, with a request/grant/acknowledge handshake toward the masters and a strobe/ready handshake toward memory and peripherals.
- Sits between the masters and the bus decoder.
- Debug has fixed top priority; core and DMA alternate round-robin. A ready timeout prevents a hung slave from locking the bus.

Parameters:
- TIMEOUT, 16, maximum WAIT cycles before a transaction is aborted with an error; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- iClk  in  1  system clock; all state changes on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iReq  in  3  per-requester transaction request, held until the matching oAck.
- iWrite  in  3  per-requester direction: 1 = write, 0 = read.
- iAddr0, iAddr1, iAddr2  in  32 each  per-requester word address.
- iWData0, iWData1, iWData2  in  32 each  per-requester write data.
- oGnt  out  3  one-hot grant, held for the whole transaction.
- oAck  out  3  one-hot, one-cycle completion pulse.
- oErr  out  1  one-cycle pulse, coincident with oAck, on timeout.
- oRData  out  32  read data, valid while oAck is high.
- oBusAddr  out  32  address to the bus decoder.
- oBusWData  out  32  write data to the bus.
- oBusWrite  out  1  bus direction.
- oBusStrobe  out  1  bus cycle active.
- iBusRData  in  32  read data from the slave.
- iBusReady  in  1  slave completion.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, iRst high at a rising edge):
  - State returns to IDLE; every output goes to 0, including all data and address buses.
  - Round-robin pointer rLast = 2, so the core wins the first core/DMA tie.
  - Wait counter = 0.
  - Reset asserted mid-transaction drops oBusStrobe and oGnt at that same edge; no oAck is issued.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any iReq bit is set, select a winner:
    - iReq[0] set: winner = 0.
    - Otherwise, if iReq[1] and iReq[2] are both set: winner = the one that is not rLast.
    - Otherwise: the single requester that is asserting.
  - At that edge: latch the winner's address, write data and iWrite onto oBusAddr, oBusWData and oBusWrite; set oBusStrobe = 1 and the oGnt bit for the winner; clear the counter; go to WAIT.
  - If no iReq bit is set, stay in IDLE.
- WAIT:
  - Hold the strobe and all bus outputs stable.
  - If iBusReady = 1 at an edge: oRData <= iBusRData (captured on writes too), go to DONE with oErr = 0.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: go to DONE with oErr = 1 and oRData = 32'h0.
  - Else: counter increments.
- DONE:
  - oAck[winner] = 1 and oErr as decided above, both for exactly one cycle.
  - oBusStrobe and oGnt drop at the edge entering DONE.
  - If the winner is 1 or 2, rLast <= winner; debug grants leave rLast unchanged.
  - Next edge: go to IDLE and clear oAck and oErr.
  - oRData holds its value until the next capture.
- Latency:
  - Request sampled at edge E0 gives strobe and grant after E0.
  - Zero-wait slave (ready sampled at E1) gives oAck after E1.
  - Back in IDLE after E2; the earliest next grant is after E3.
  - Net result: at most one transaction per 3 cycles, plus wait cycles.
- A master must deassert iReq in the cycle oAck is seen. If iReq is still high when IDLE samples it, that is a new request.
- iReq deasserting during WAIT is ignored: the transaction completes and oAck still pulses.
- Changes on a requester's iAddr, iWData or iWrite after the grant are ignored.
- No preemption: debug waits for the current transaction to reach DONE.
- iBusReady in IDLE or DONE is ignored.
- iBusReady and timeout in the same cycle: ready wins, oErr = 0.
- Simultaneous requests from all three masters: debug first, then core, then DMA (with rLast = 2 after reset). A steady core+DMA contention alternates strictly 1, 2, 1, 2.
- The counter saturates logically at TIMEOUT-1 and never wraps inside WAIT.

Test Plan:
- Reset, then iReq = 3'b010, iWrite1 = 0, iAddr1 = 32'h100, slave ready next cycle with data 32'hCAFEF00D -> oGnt = 010 and oBusStrobe = 1 with oBusAddr = 32'h100 one cycle after request; oAck = 010 with oRData = 32'hCAFEF00D two cycles after request; oErr = 0.
- iReq = 3'b110 held continuously, each master dropping and re-raising iReq after its ack, zero-wait slave -> grant order 1, 2, 1, 2; each oAck exactly one cycle long; 3 cycles per transaction.
- iReq = 3'b111 at the same cycle -> debug served first, then core, then DMA; oBusWrite and oBusWData match each master's inputs during its strobe.
- TIMEOUT = 16, slave never asserts ready -> strobe high for exactly 16 cycles, then oAck with oErr = 1 and oRData = 0; the next request is served normally.
- Debug raises iReq[0] during a core WAIT with 5 wait states -> core completes uninterrupted; debug is granted in the first IDLE after the core's ack.
- iRst asserted on the 3rd WAIT cycle of a DMA write -> all outputs 0 at the next edge, no oAck pulse; after release, a core request wins the core/DMA tie (rLast = 2).
